tick_interval_timer: RTL and testbench
======================================

// Module: tick_interval_timer
// PURPOSE
//   Programmable down-counting interval timer driven by a prescaler tick.
//   Sits directly downstream of the free-running binary counter: that
//   counter's max_tick drives tick_in, and this block counts those ticks.
//   Supports one-shot and periodic modes. Emits a one-cycle expire pulse
//   when the programmed number of ticks has elapsed.
// PARAMETERS
//   W    default 8    width of load_val / count; max interval 2**W-1 ticks
// PORTS
//   clk       in   1   system clock; all logic on rising edge
//   reset     in   1   synchronous, active-low reset (0 = reset at posedge clk)
//   tick_in   in   1   count-enable strobe, one clk wide (prescaler max_tick)
//   start     in   1   load load_val/periodic and (re)start the timer
//   stop      in   1   abort the run; return to IDLE without expire
//   periodic  in   1   sampled on start: 1 = auto-reload, 0 = one-shot
//   load_val  in   W   interval in ticks; sampled on start; 0 = invalid
//   busy      out  1   1 while in RUN (registered)
//   expire    out  1   one-cycle pulse on interval completion (registered)
//   count     out  W   remaining ticks (registered)
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE, busy=0, expire=0, count=0,
//     reload_r=0, periodic_r=0. Reset overrides every other input, also mid-RUN.
//   FSM states: IDLE, RUN. busy == (state==RUN). expire defaults to 0 each edge.
//   Priority at each edge in RUN: stop > start > tick_in.
//   IDLE:
//     - start=1, load_val!=0: count<=load_val, reload_r<=load_val,
//       periodic_r<=periodic, go RUN. A tick_in in the same cycle is not counted.
//     - start=1, load_val==0: ignored; stay IDLE, no expire.
//     - tick_in and stop: no effect.
//   RUN:
//     - stop=1: go IDLE, count<=0, no expire (even if tick_in=1 and count==1).
//     - start=1, load_val!=0: restart; reload count/reload_r/periodic_r, no expire.
//     - start=1, load_val==0: start ignored; the tick rule applies this cycle.
//     - tick_in=1, count>1: count<=count-1.
//     - tick_in=1, count==1: expire<=1 for exactly one cycle; then
//         periodic_r=1: count<=reload_r, stay RUN;
//         periodic_r=0: count<=0, go IDLE (busy falls on the same edge).
//     - tick_in=0: hold.
//   Latency: start at edge E0 with load N and tick_in held 1 -> count=N after
//     E0 and decrements each edge. expire is high in the cycle after edge E0+N.
//     A one-shot run takes N ticks; a periodic run expires every N ticks.
//   Arithmetic: unsigned W-bit. count never wraps: it never decrements below 1
//     while in RUN and is 0 only in IDLE.
//   Inputs are sampled only on clk. tick_in wider than one clock counts once
//     per clock in which it is high.
// TESTING
//   1 reset=0 for 2 cycles, then reset=1 -> busy=0, expire=0, count=0.
//   2 W=8, load_val=3, periodic=0, tick_in=1 constant, start pulse -> count
//     3,2,1; expire=1 for one cycle after the 3rd tick; busy=0 and count=0
//     on the same edge.
//   3 load_val=2, periodic=1, tick_in every 4th clk -> expire every 8 clks,
//     count sequence 2,1,2,1...; busy stays 1; stop pulse -> IDLE, no expire.
//   4 RUN with count==1, tick_in=1 and stop=1 in the same cycle -> no expire,
//     IDLE, count=0. Repeat with start=1 (load 5) instead of stop -> no
//     expire, count=5, busy=1.
//   5 start with load_val=0 while in IDLE -> stays IDLE, busy=0, count=0.
//     Apply reset=0 mid-RUN (count=7) -> next edge: IDLE, count=0, expire=0.
//   6 load_val=255 (W=8), one-shot, tick_in constant -> exactly 255 ticks to
//     expire, no wrap; expire=1 for one cycle only.

Source files
------------

// File: rtl/tick_interval_timer_if.sv
// Control/status bundle for tick_interval_timer: the controller drives the
// strobes and load value, the timer returns busy/expire/count.
interface tick_interval_timer_if #(
   parameter int W = 8
);
   logic         tick_in;
   logic         start;
   logic         stop;
   logic         periodic;
   logic [W-1:0] load_val;
   logic         busy;
   logic         expire;
   logic [W-1:0] count;

   modport master (
      output tick_in, start, stop, periodic, load_val,
      input  busy, expire, count
   );

   modport slave (
      input  tick_in, start, stop, periodic, load_val,
      output busy, expire, count
   );
endinterface

// File: rtl/tick_interval_timer.sv
// Programmable down-counting interval timer advanced by a prescaler tick;
// one-shot or auto-reload, with a one-cycle expire pulse.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | stopped, count held at 0, waiting for start
//   RUN   | counting ticks down from the loaded interval
module tick_interval_timer #(
   parameter int W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   tick_interval_timer_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] ZERO = '0;

   state_t       state_q,    state_d;
   logic [W-1:0] count_q,    count_d;
   logic [W-1:0] reload_q,   reload_d;
   logic         periodic_q, periodic_d;
   logic         expire_q,   expire_d;

   logic load_ok;
   assign load_ok = bus.start && (bus.load_val != ZERO);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         count_q    <= ZERO;
         reload_q   <= ZERO;
         periodic_q <= 1'b0;
         expire_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         reload_q   <= reload_d;
         periodic_q <= periodic_d;
         expire_q   <= expire_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      reload_d   = reload_q;
      periodic_d = periodic_q;
      expire_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (load_ok) begin
               count_d    = bus.load_val;
               reload_d   = bus.load_val;
               periodic_d = bus.periodic;
               state_d    = RUN;
            end
         end
         RUN: begin
            // stop beats start beats tick; a zero-length start falls through to the tick rule
            if (bus.stop) begin
               count_d = ZERO;
               state_d = IDLE;
            end else if (load_ok) begin
               count_d    = bus.load_val;
               reload_d   = bus.load_val;
               periodic_d = bus.periodic;
            end else if (bus.tick_in) begin
               if (count_q > ONE) begin
                  count_d = count_q - ONE;
               end else begin
                  expire_d = 1'b1;
                  if (periodic_q) begin
                     count_d = reload_q;
                  end else begin
                     count_d = ZERO;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            count_d = ZERO;
         end
      endcase
   end

   assign bus.busy   = (state_q == RUN);
   assign bus.expire = expire_q;
   assign bus.count  = count_q;

endmodule

// File: tb/tb_tick_interval_timer.sv
// Directed bench for tick_interval_timer: a behavioural reference checked
// every cycle, plus hand-computed literal expectations.
module tb_tick_interval_timer;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   tick_interval_timer_if #(.W(8)) tif ();

   tick_interval_timer #(.W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: "remaining ticks" plus an active flag, updated from the
   // inputs seen at each rising edge.
   logic       m_active;
   logic [7:0] m_left;
   logic [7:0] m_interval;
   logic       m_repeat;
   logic       m_fire;
   logic       cmp_en;

   initial begin
      m_active = 1'b0; m_left = '0; m_interval = '0; m_repeat = 1'b0; m_fire = 1'b0;
      cmp_en = 1'b0;
   end

   always @(posedge clk) begin
      m_fire <= 1'b0;
      if (!reset) begin
         m_active <= 1'b0; m_left <= '0; m_interval <= '0; m_repeat <= 1'b0;
      end else if (m_active && tif.stop) begin
         m_active <= 1'b0; m_left <= '0;
      end else if (tif.start && tif.load_val != 0) begin
         m_active <= 1'b1; m_left <= tif.load_val;
         m_interval <= tif.load_val; m_repeat <= tif.periodic;
      end else if (m_active && tif.tick_in) begin
         if (m_left == 8'd1) begin
            m_fire   <= 1'b1;
            m_left   <= m_repeat ? m_interval : 8'd0;
            m_active <= m_repeat;
         end else begin
            m_left <= m_left - 8'd1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_busy",   int'(tif.busy),   int'(m_active));
         chk("model_expire", int'(tif.expire), int'(m_fire));
         chk("model_count",  int'(tif.count),  int'(m_left));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic sp, input logic tk,
                        input logic per, input logic [7:0] lv);
      tif.start = st; tif.stop = sp; tif.tick_in = tk;
      tif.periodic = per; tif.load_val = lv;
   endtask

   int n_exp;
   int k;

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b0;
      drive(0, 0, 0, 0, 8'd0);

      // reset
      step(); cmp_en = 1'b1;
      step();
      reset = 1'b1;
      step();
      chk("rst_busy", int'(tif.busy), 0);
      chk("rst_expire", int'(tif.expire), 0);
      chk("rst_count", int'(tif.count), 0);

      // one-shot, load 3, tick every clock
      drive(1, 0, 1, 0, 8'd3);
      step();
      tif.start = 1'b0;
      chk("os_count3", int'(tif.count), 3);
      chk("os_busy", int'(tif.busy), 1);
      step(); chk("os_count2", int'(tif.count), 2);
      step(); chk("os_count1", int'(tif.count), 1);
      chk("os_noexp_early", int'(tif.expire), 0);
      step();
      chk("os_expire", int'(tif.expire), 1);
      chk("os_busy_fall", int'(tif.busy), 0);
      chk("os_count0", int'(tif.count), 0);
      step(); chk("os_expire_one_cycle", int'(tif.expire), 0);

      // periodic, load 2, tick every 4th clock
      drive(1, 0, 0, 1, 8'd2);
      step();
      tif.start = 1'b0;
      n_exp = 0;
      for (int i = 0; i < 16; i++) begin
         tif.tick_in = (i % 4 == 3);
         step();
         if (tif.expire) n_exp++;
         if (i == 3) chk("per_count1", int'(tif.count), 1);
      end
      chk("per_expires", n_exp, 2);
      chk("per_busy", int'(tif.busy), 1);
      chk("per_reload", int'(tif.count), 2);
      drive(0, 1, 0, 1, 8'd0);
      step();
      chk("per_stop_busy", int'(tif.busy), 0);
      chk("per_stop_expire", int'(tif.expire), 0);
      chk("per_stop_count", int'(tif.count), 0);

      // stop wins over final tick
      drive(1, 0, 0, 0, 8'd1);
      step();
      drive(0, 1, 1, 0, 8'd0);
      step();
      chk("stop_tick_expire", int'(tif.expire), 0);
      chk("stop_tick_busy", int'(tif.busy), 0);
      chk("stop_tick_count", int'(tif.count), 0);

      // restart wins over final tick
      drive(1, 0, 0, 0, 8'd1);
      step();
      drive(1, 0, 1, 0, 8'd5);
      step();
      chk("restart_expire", int'(tif.expire), 0);
      chk("restart_count", int'(tif.count), 5);
      chk("restart_busy", int'(tif.busy), 1);

      // zero-length start in RUN is ignored, tick still counts
      drive(1, 0, 1, 0, 8'd0);
      step();
      chk("zero_start_run_count", int'(tif.count), 4);
      drive(0, 1, 0, 0, 8'd0);
      step();

      // zero-length start in IDLE
      drive(1, 0, 1, 0, 8'd0);
      step();
      chk("zero_start_idle_busy", int'(tif.busy), 0);
      chk("zero_start_idle_count", int'(tif.count), 0);

      // reset mid-run
      drive(1, 0, 0, 0, 8'd7);
      step();
      chk("pre_rst_count", int'(tif.count), 7);
      drive(0, 0, 1, 0, 8'd0);
      reset = 1'b0;
      step();
      chk("mid_rst_busy", int'(tif.busy), 0);
      chk("mid_rst_count", int'(tif.count), 0);
      chk("mid_rst_expire", int'(tif.expire), 0);
      reset = 1'b1;
      step();

      // full-scale one-shot
      drive(1, 0, 1, 0, 8'd255);
      step();
      tif.start = 1'b0;
      chk("max_count", int'(tif.count), 255);
      k = 0;
      while (!tif.expire && k < 300) begin
         step();
         k++;
      end
      chk("max_ticks", k, 255);
      chk("max_end_busy", int'(tif.busy), 0);
      step();
      chk("max_expire_one_cycle", int'(tif.expire), 0);
      chk("max_no_wrap", int'(tif.count), 0);

      step();
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
